// File: rtl/health_tracker.sv
// Health tracker: keeps player and NPC hit points during a battle, applies
// at most one hit per frame per fighter and gives each fighter a short
// invulnerability window after taking damage. Dead flags stay set until Reset.
module health_tracker #(
    parameter int HP_W          = 8,
    parameter int MAX_HP        = 100,
    parameter int DAMAGE        = 10,
    parameter int INVULN_FRAMES = 30
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    input  logic            battle_active,
    input  logic            player_hit,
    input  logic            npc_hit,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] npc_hp,
    output logic            Player_Dead,
    output logic            NPC_Dead,
    output logic            player_hurt,
    output logic            npc_hurt
);

    // A zero-length window still needs a one-bit counter to keep widths legal.
    localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    localparam logic [HP_W-1:0]  MAX_HP_V   = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]  DAMAGE_V   = HP_W'(DAMAGE);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               HAS_WINDOW = (INVULN_FRAMES > 0);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } fighter_state_e;

    // Index 0 is the player, index 1 is the NPC; both run the same machine.
    fighter_state_e   state_q   [2];
    fighter_state_e   state_d   [2];
    logic [HP_W-1:0]  hp_q      [2];
    logic [HP_W-1:0]  hp_d      [2];
    logic [CNT_W-1:0] cnt_q     [2];
    logic [CNT_W-1:0] cnt_d     [2];
    logic             pending_q [2];
    logic             pending_d [2];
    logic             hit       [2];

    logic frame_clk_delayed_q;
    logic frame_clk_delayed_d;
    logic frame_edge;

    assign hit[0] = player_hit;
    assign hit[1] = npc_hit;

    // Rising edge of the vertical sync marks the start of a new frame.
    always_comb begin
        frame_clk_delayed_d = frame_clk;
        frame_edge          = frame_clk & ~frame_clk_delayed_q;
    end

    // State register: all fighter state plus the frame edge detector.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_delayed_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= READY;
                hp_q[i]      <= MAX_HP_V;
                cnt_q[i]     <= '0;
                pending_q[i] <= 1'b0;
            end
        end else begin
            frame_clk_delayed_q <= frame_clk_delayed_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= state_d[i];
                hp_q[i]      <= hp_d[i];
                cnt_q[i]     <= cnt_d[i];
                pending_q[i] <= pending_d[i];
            end
        end
    end

    // Next state: latch hits during a frame, apply them on the frame edge,
    // run the window countdown, and freeze everything outside a battle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]   = state_q[i];
            hp_d[i]      = hp_q[i];
            cnt_d[i]     = cnt_q[i];
            pending_d[i] = pending_q[i];

            if (!battle_active) begin
                pending_d[i] = 1'b0;
            end else begin
                case (state_q[i])
                    READY: begin
                        pending_d[i] = pending_q[i] | hit[i];
                        if (frame_edge && pending_q[i]) begin
                            pending_d[i] = 1'b0;
                            if (hp_q[i] <= DAMAGE_V) begin
                                hp_d[i]    = '0;
                                state_d[i] = DEAD;
                            end else begin
                                hp_d[i] = hp_q[i] - DAMAGE_V;
                                if (HAS_WINDOW) begin
                                    state_d[i] = INVULN;
                                    cnt_d[i]   = CNT_LOAD;
                                end
                            end
                        end
                    end
                    INVULN: begin
                        pending_d[i] = 1'b0;
                        if (frame_edge) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                            if (cnt_q[i] == CNT_ONE) begin
                                state_d[i] = READY;
                            end
                        end
                    end
                    DEAD: begin
                        pending_d[i] = 1'b0;
                        hp_d[i]      = '0;
                    end
                    default: begin
                        state_d[i]   = READY;
                        pending_d[i] = 1'b0;
                    end
                endcase
            end
        end
    end

    // Outputs are decoded straight from the registered state.
    always_comb begin
        player_hp   = hp_q[0];
        npc_hp      = hp_q[1];
        Player_Dead = (state_q[0] == DEAD);
        NPC_Dead    = (state_q[1] == DEAD);
        player_hurt = (state_q[0] == INVULN);
        npc_hurt    = (state_q[1] == INVULN);
    end

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker. A default instance covers the window
// behaviour; a second instance with heavy damage and no window checks that
// HP saturates at zero instead of wrapping.
module tb_health_tracker;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       battle_active;
    logic       player_hit;
    logic       npc_hit;

    logic [7:0] player_hp;
    logic [7:0] npc_hp;
    logic       Player_Dead;
    logic       NPC_Dead;
    logic       player_hurt;
    logic       npc_hurt;

    logic [7:0] player_hp2;
    logic [7:0] npc_hp2;
    logic       Player_Dead2;
    logic       NPC_Dead2;
    logic       player_hurt2;
    logic       npc_hurt2;

    int testCount = 0;
    int failCount = 0;

    health_tracker dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .battle_active(battle_active),
        .player_hit   (player_hit),
        .npc_hit      (npc_hit),
        .player_hp    (player_hp),
        .npc_hp       (npc_hp),
        .Player_Dead  (Player_Dead),
        .NPC_Dead     (NPC_Dead),
        .player_hurt  (player_hurt),
        .npc_hurt     (npc_hurt)
    );

    health_tracker #(
        .HP_W         (8),
        .MAX_HP       (100),
        .DAMAGE       (30),
        .INVULN_FRAMES(0)
    ) dut2 (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .battle_active(battle_active),
        .player_hit   (player_hit),
        .npc_hit      (npc_hit),
        .player_hp    (player_hp2),
        .npc_hp       (npc_hp2),
        .Player_Dead  (Player_Dead2),
        .NPC_Dead     (NPC_Dead2),
        .player_hurt  (player_hurt2),
        .npc_hurt     (npc_hurt2)
    );

    // 100 MHz bench clock; the real design runs at 50 MHz but timing is cycle based.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Hold the given levels, give them one cycle to be seen, then run frame edges.
    task automatic applyStimulus(input logic p, input logic n, input logic b,
                                 input int frames);
        @(negedge Clk);
        player_hit    = p;
        npc_hit       = n;
        battle_active = b;
        @(negedge Clk);
        for (int f = 0; f < frames; f++) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    // One-cycle synchronous reset with all inputs idle.
    task automatic doReset();
        @(negedge Clk);
        Reset         = 1'b1;
        player_hit    = 1'b0;
        npc_hit       = 1'b0;
        battle_active = 1'b0;
        frame_clk     = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset         = 1'b1;
        frame_clk     = 1'b0;
        battle_active = 1'b0;
        player_hit    = 1'b0;
        npc_hit       = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // Reset values
        checkOutput("rst_player_hp", player_hp, 100);
        checkOutput("rst_npc_hp", npc_hp, 100);
        checkOutput("rst_player_dead", Player_Dead, 0);
        checkOutput("rst_npc_dead", NPC_Dead, 0);
        checkOutput("rst_player_hurt", player_hurt, 0);
        checkOutput("rst_npc_hurt", npc_hurt, 0);
        checkOutput("rst_dut2_hp", player_hp2, 100);

        // Single-cycle NPC hit pulse mid-frame, then one frame edge
        battle_active = 1'b1;
        repeat (2) @(negedge Clk);
        npc_hit = 1'b1;
        @(negedge Clk);
        npc_hit = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("pulse_before_fe", npc_hp, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("pulse_npc_hp", npc_hp, 90);
        checkOutput("pulse_npc_hurt", npc_hurt, 1);
        checkOutput("pulse_player_hp", player_hp, 100);
        checkOutput("pulse_dut2_npc_hp", npc_hp2, 70);
        checkOutput("pulse_dut2_npc_hurt", npc_hurt2, 0);

        // Held hit: damage, 30-edge window, then a second hit
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("hold_fe1_hp", npc_hp, 90);
        checkOutput("hold_fe1_hurt", npc_hurt, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 29);
        checkOutput("hold_fe30_hp", npc_hp, 90);
        checkOutput("hold_fe30_hurt", npc_hurt, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("hold_fe31_hp", npc_hp, 90);
        checkOutput("hold_fe31_hurt", npc_hurt, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("hold_fe32_hp", npc_hp, 80);
        checkOutput("hold_fe32_hurt", npc_hurt, 1);
        checkOutput("hold_dut2_npc_dead", NPC_Dead2, 1);
        checkOutput("hold_dut2_npc_hp", npc_hp2, 0);

        // Saturation without wrap on the no-window instance
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 3);
        checkOutput("sat_dut2_hp10", player_hp2, 10);
        checkOutput("sat_dut2_alive", Player_Dead2, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("sat_dut2_hp0", player_hp2, 0);
        checkOutput("sat_dut2_dead", Player_Dead2, 1);

        // Player worn down to zero; death is sticky
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1);
            applyStimulus(1'b0, 1'b0, 1'b1, 30);
        end
        checkOutput("death_hp10", player_hp, 10);
        checkOutput("death_alive", Player_Dead, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("death_hp0", player_hp, 0);
        checkOutput("death_flag", Player_Dead, 1);
        checkOutput("death_not_hurt", player_hurt, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2);
        checkOutput("death_extra_hit_hp", player_hp, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        checkOutput("death_sticky", Player_Dead, 1);
        checkOutput("death_npc_untouched", npc_hp, 100);

        // Both fighters die on the same edge
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1);
            applyStimulus(1'b0, 1'b0, 1'b1, 30);
        end
        checkOutput("tie_player_hp10", player_hp, 10);
        checkOutput("tie_npc_hp10", npc_hp, 10);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("tie_player_dead", Player_Dead, 1);
        checkOutput("tie_npc_dead", NPC_Dead, 1);
        checkOutput("tie_player_hp0", player_hp, 0);
        checkOutput("tie_npc_hp0", npc_hp, 0);

        // Reset while dead
        doReset();
        checkOutput("rst_dead_player_flag", Player_Dead, 0);
        checkOutput("rst_dead_npc_flag", NPC_Dead, 0);
        checkOutput("rst_dead_player_hp", player_hp, 100);

        // Battle paused: no damage, window countdown frozen
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("pause_start_hp", npc_hp, 90);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        checkOutput("pause_player_hp", player_hp, 100);
        checkOutput("pause_npc_hp", npc_hp, 90);
        checkOutput("pause_npc_hurt", npc_hurt, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 19);
        checkOutput("pause_resume_hurt", npc_hurt, 1);
        checkOutput("pause_no_stale_hit", player_hp, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("pause_window_done", npc_hurt, 0);

        // Reset in the middle of a window
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("rst_win_pre_hurt", npc_hurt, 1);
        doReset();
        checkOutput("rst_win_hp", npc_hp, 100);
        checkOutput("rst_win_hurt", npc_hurt, 0);

        // Hit coincident with a frame edge lands on the following edge
        battle_active = 1'b1;
        @(negedge Clk);
        npc_hit   = 1'b1;
        frame_clk = 1'b1;
        @(negedge Clk);
        npc_hit   = 1'b0;
        frame_clk = 1'b0;
        @(negedge Clk);
        checkOutput("coinc_not_yet", npc_hp, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("coinc_applied", npc_hp, 90);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
